// File: rtl/trap_controller_if.sv
// ---------------------------------------------------------------------------
// trap_controller_if
//
// MMIO register bus between the interconnect and the trap controller.
//
// Signals:
//   busWriteEnable  register write strobe from the interconnect
//   busRegSelect    register select: 0 MASK, 1 PENDING (W1C), 2 GIE, 3 STATUS
//   busWriteData    write data
//   busReadData     combinational read data for the selected register
//
// Modports:
//   master  interconnect side (drives strobe/select/data, reads data back)
//   slave   trap controller side
// ---------------------------------------------------------------------------
interface trap_controller_if;
    logic        busWriteEnable;
    logic [1:0]  busRegSelect;
    logic [31:0] busWriteData;
    logic [31:0] busReadData;

    modport master (
        output busWriteEnable,
        output busRegSelect,
        output busWriteData,
        input  busReadData
    );

    modport slave (
        input  busWriteEnable,
        input  busRegSelect,
        input  busWriteData,
        output busReadData
    );
endinterface

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Trap/interrupt sequencer in front of the core. External interrupt lines are
// synchronised, edge-detected and latched as pending bits. At an instruction
// boundary an eligible interrupt is taken: the CSR unit is told to capture the
// PC into MEPC and the PC mux is steered to the trap vector. A retiring MRET
// steers the PC mux back to MEPC.
//
// Ports:
//   clock           core clock
//   resetActiveLow  asynchronous active-low reset
//   irqLines        asynchronous level-high interrupt requests
//   instrRetire     core is at an instruction boundary this cycle
//   mretDetected    retiring instruction is MRET (qualified by instrRetire)
//   bus             MMIO register interface (slave side)
//   csrWriteEnable  one-cycle pulse: CSR unit captures PC into MEPC
//   trapTaken       one-cycle pulse: PC mux selects trapVector
//   trapReturn      one-cycle pulse: PC mux selects mepcValue
//   trapVector      constant handler entry address
//   trapCause       index of the interrupt most recently taken
//   inTrap          high while the handler runs
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               resetActiveLow,
    input  logic [NUM_IRQ-1:0] irqLines,
    input  logic               instrRetire,
    input  logic               mretDetected,
    trap_controller_if.slave   bus,
    output logic               csrWriteEnable,
    output logic               trapTaken,
    output logic               trapReturn,
    output logic [31:0]        trapVector,
    output logic [31:0]        trapCause,
    output logic               inTrap
);

    // The encoding is software-visible through STATUS, so it is fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_MASK    = 2'd0;
    localparam logic [1:0] SEL_PENDING = 2'd1;
    localparam logic [1:0] SEL_GIE     = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    state_t             state_q, state_d;
    logic [31:0]        cause_q, cause_d;
    logic               csr_we_q, csr_we_d;
    logic               taken_q, taken_d;
    logic               return_q, return_d;
    logic               in_trap_q, in_trap_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] active;
    logic               eligible;
    logic [31:0]        win_idx;
    logic [31:0]        read_data;
    logic               unused_wdata;

    // Only the low NUM_IRQ write-data bits are ever stored.
    assign unused_wdata = ^bus.busWriteData;

    // Synchroniser chain followed by a rising-edge detector; prev_q holds the
    // last synchronised value so a held-high line only pends once.
    always_comb begin
        sync_d[0] = irqLines;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Register writes and pending update. A bus W1C loses to a same-cycle
    // edge, but the clear of the bit being taken beats everything.
    always_comb begin
        mask_d = mask_q;
        gie_d  = gie_q;
        w1c    = '0;
        if (bus.busWriteEnable) begin
            case (bus.busRegSelect)
                SEL_MASK:    mask_d = bus.busWriteData[NUM_IRQ-1:0];
                SEL_PENDING: w1c    = bus.busWriteData[NUM_IRQ-1:0];
                SEL_GIE:     gie_d  = bus.busWriteData[0];
                default:     ;
            endcase
        end
        pending_d = (pending_q & ~w1c) | rise;
        if (state_q == CAPTURE) begin
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                if (cause_q == 32'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        active   = pending_q & mask_q;
        eligible = gie_q & (|active);
        win_idx  = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_idx = 32'(i);
            end
        end
    end

    // Next state plus the pulse/level outputs, which are registered from the
    // next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (eligible && instrRetire) begin
                    state_d = CAPTURE;
                    cause_d = win_idx;
                end
            end
            CAPTURE: state_d = HANDLER;
            HANDLER: begin
                if (mretDetected && instrRetire) begin
                    state_d = RETURN;
                end
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        csr_we_d  = (state_d == CAPTURE);
        taken_d   = (state_d == CAPTURE);
        return_d  = (state_d == RETURN);
        in_trap_d = (state_d == HANDLER);
    end

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            state_q   <= IDLE;
            cause_q   <= '0;
            csr_we_q  <= 1'b0;
            taken_q   <= 1'b0;
            return_q  <= 1'b0;
            in_trap_q <= 1'b0;
        end else begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            state_q   <= state_d;
            cause_q   <= cause_d;
            csr_we_q  <= csr_we_d;
            taken_q   <= taken_d;
            return_q  <= return_d;
            in_trap_q <= in_trap_d;
        end
    end

    // Register read mux; unused upper bits read as zero.
    always_comb begin
        read_data = '0;
        case (bus.busRegSelect)
            SEL_MASK:    read_data[NUM_IRQ-1:0] = mask_q;
            SEL_PENDING: read_data[NUM_IRQ-1:0] = pending_q;
            SEL_GIE:     read_data[0]           = gie_q;
            SEL_STATUS:  read_data[2:0]         = {state_q, in_trap_q};
            default:     read_data              = '0;
        endcase
    end

    assign bus.busReadData = read_data;
    assign csrWriteEnable  = csr_we_q;
    assign trapTaken       = taken_q;
    assign trapReturn      = return_q;
    assign trapVector      = TRAP_VECTOR;
    assign trapCause       = cause_q;
    assign inTrap          = in_trap_q;

endmodule

// File: tb/tb_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_trap_controller
//
// Directed scenarios followed by a randomized run. Every cycle the DUT is
// compared against a behavioural model built from a delay line of sampled
// irq values and simple trap/handler/return flags.
// ---------------------------------------------------------------------------
module tb_trap_controller;

    localparam int          NUM_IRQ     = 4;
    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

    localparam logic [1:0] SEL_MASK    = 2'd0;
    localparam logic [1:0] SEL_PENDING = 2'd1;
    localparam logic [1:0] SEL_GIE     = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    logic               clock = 1'b0;
    logic               resetActiveLow;
    logic [NUM_IRQ-1:0] irqLines;
    logic               instrRetire;
    logic               mretDetected;
    logic               csrWriteEnable;
    logic               trapTaken;
    logic               trapReturn;
    logic [31:0]        trapVector;
    logic [31:0]        trapCause;
    logic               inTrap;

    trap_controller_if bus_if();

    trap_controller #(
        .NUM_IRQ    (NUM_IRQ),
        .TRAP_VECTOR(TRAP_VECTOR),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock         (clock),
        .resetActiveLow(resetActiveLow),
        .irqLines      (irqLines),
        .instrRetire   (instrRetire),
        .mretDetected  (mretDetected),
        .bus           (bus_if),
        .csrWriteEnable(csrWriteEnable),
        .trapTaken     (trapTaken),
        .trapReturn    (trapReturn),
        .trapVector    (trapVector),
        .trapCause     (trapCause),
        .inTrap        (inTrap)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_passed = 0;

    // Reference model state.
    logic [NUM_IRQ-1:0] m_hist [$];
    logic [NUM_IRQ-1:0] m_pending;
    logic [NUM_IRQ-1:0] m_mask;
    logic               m_gie;
    logic               m_taken;
    logic               m_return;
    logic               m_in_trap;
    int                 m_cause;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC_STAGES + 2; i++) m_hist.push_back('0);
        m_pending = '0;
        m_mask    = '0;
        m_gie     = 1'b0;
        m_taken   = 1'b0;
        m_return  = 1'b0;
        m_in_trap = 1'b0;
        m_cause   = 0;
    endtask

    // One clock edge of the model, using the inputs as the DUT sampled them.
    task automatic model_step();
        logic [NUM_IRQ-1:0] rise;
        logic [NUM_IRQ-1:0] w1c;
        logic [NUM_IRQ-1:0] nxt;
        logic [NUM_IRQ-1:0] act;
        int                 win;
        if (!resetActiveLow) begin
            model_reset();
            return;
        end
        m_hist.push_front(irqLines);
        void'(m_hist.pop_back());
        rise = m_hist[SYNC_STAGES] & ~m_hist[SYNC_STAGES+1];
        w1c  = '0;
        if (bus_if.busWriteEnable && bus_if.busRegSelect == SEL_PENDING)
            w1c = bus_if.busWriteData[NUM_IRQ-1:0];
        nxt = (m_pending & ~w1c) | rise;
        if (m_taken) nxt[m_cause] = 1'b0;

        act = m_pending & m_mask;
        win = -1;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (act[i]) win = i;

        if (m_taken) begin
            m_taken   = 1'b0;
            m_in_trap = 1'b1;
        end else if (m_in_trap) begin
            if (instrRetire && mretDetected) begin
                m_in_trap = 1'b0;
                m_return  = 1'b1;
            end
        end else if (m_return) begin
            m_return = 1'b0;
        end else if (m_gie && win >= 0 && instrRetire) begin
            m_taken = 1'b1;
            m_cause = win;
        end

        if (bus_if.busWriteEnable && bus_if.busRegSelect == SEL_MASK)
            m_mask = bus_if.busWriteData[NUM_IRQ-1:0];
        if (bus_if.busWriteEnable && bus_if.busRegSelect == SEL_GIE)
            m_gie = bus_if.busWriteData[0];
        m_pending = nxt;
    endtask

    task automatic applyStimulus(input logic [NUM_IRQ-1:0] irq, input logic retire, input logic mret,
                                 input logic we, input logic [1:0] sel, input logic [31:0] wd);
        irqLines              = irq;
        instrRetire           = retire;
        mretDetected          = mret;
        bus_if.busWriteEnable = we;
        bus_if.busRegSelect   = sel;
        bus_if.busWriteData   = wd;
    endtask

    // Compares every output and all four readable registers with the model.
    task automatic checkOutput();
        logic [31:0] exp_rd;
        bus_if.busWriteEnable = 1'b0;
        checkValue("trapTaken",      32'(trapTaken),      32'(m_taken));
        checkValue("csrWriteEnable", 32'(csrWriteEnable), 32'(m_taken));
        checkValue("trapReturn",     32'(trapReturn),     32'(m_return));
        checkValue("inTrap",         32'(inTrap),         32'(m_in_trap));
        checkValue("trapCause",      trapCause,           32'(m_cause));
        checkValue("trapVector",     trapVector,          TRAP_VECTOR);
        for (int s = 0; s < 4; s++) begin
            bus_if.busRegSelect = 2'(s);
            #1;
            case (2'(s))
                SEL_MASK:    exp_rd = 32'(m_mask);
                SEL_PENDING: exp_rd = 32'(m_pending);
                SEL_GIE:     exp_rd = 32'(m_gie);
                default:     exp_rd = m_in_trap ? 32'h5 : 32'h0;
            endcase
            if (2'(s) != SEL_STATUS || (!m_taken && !m_return))
                checkValue($sformatf("read_sel%0d", s), bus_if.busReadData, exp_rd);
        end
    endtask

    task automatic cycle(input logic [NUM_IRQ-1:0] irq, input logic retire, input logic mret,
                         input logic we, input logic [1:0] sel, input logic [31:0] wd);
        applyStimulus(irq, retire, mret, we, sel, wd);
        @(posedge clock);
        model_step();
        @(negedge clock);
        checkOutput();
    endtask

    task automatic readReg(input logic [1:0] sel, output logic [31:0] val);
        bus_if.busWriteEnable = 1'b0;
        bus_if.busRegSelect   = sel;
        #1;
        val = bus_if.busReadData;
    endtask

    initial begin
        int          lat;
        logic        got;
        int          n_ret;
        int          n_take;
        logic [31:0] rd;
        logic [NUM_IRQ-1:0] rirq;

        // Reset state
        resetActiveLow = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, SEL_MASK, 32'h0);
        model_reset();
        @(negedge clock);
        checkOutput();
        cycle('0, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle('0, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        resetActiveLow = 1'b1;

        // Single irq 1 with MASK=2, GIE=1, retire held high
        cycle('0, 1'b1, 1'b0, 1'b1, SEL_MASK, 32'h2);
        cycle('0, 1'b1, 1'b0, 1'b1, SEL_GIE,  32'h1);
        lat = 11;
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
            if (trapTaken === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        checkValue("irq_to_trap_latency", 32'(lat), 32'd4);
        cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        checkValue("cause_irq1", trapCause, 32'd1);
        checkValue("intrap_irq1", 32'(inTrap), 32'd1);
        readReg(SEL_PENDING, rd);
        checkValue("pending_after_take", rd, 32'h0);
        cycle(4'h2, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
        checkValue("mret_return_pulse", 32'(trapReturn), 32'd1);
        cycle('0, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);

        // Simultaneous irq 0 and 2, then irq 3 during the handler
        cycle('0, 1'b0, 1'b0, 1'b1, SEL_MASK, 32'hF);
        for (int i = 0; i < 5; i++) cycle(4'h5, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        checkValue("cause_lowest_wins", trapCause, 32'd0);
        readReg(SEL_PENDING, rd);
        checkValue("pending2_kept", rd & 32'h4, 32'h4);
        n_take = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(4'hD, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
            if (trapTaken === 1'b1) n_take++;
        end
        checkValue("no_nested_trap", 32'(n_take), 32'd0);
        readReg(SEL_STATUS, rd);
        checkValue("status_handler", rd, 32'h5);
        readReg(SEL_PENDING, rd);
        checkValue("pending3_accumulated", rd & 32'h8, 32'h8);
        cycle(4'hD, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
        cycle(4'hD, 1'b0, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'hD, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        checkValue("next_trap_taken", 32'(trapTaken), 32'd1);
        checkValue("next_trap_cause2", trapCause, 32'd2);
        for (int i = 0; i < 3; i++) cycle(4'hD, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'hD, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
        for (int i = 0; i < 4; i++) cycle(4'h0, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h0, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);

        // GIE gating, then W1C before enabling
        cycle('0, 1'b0, 1'b0, 1'b1, SEL_GIE, 32'h0);
        cycle('0, 1'b0, 1'b0, 1'b1, SEL_PENDING, 32'hF);
        for (int i = 0; i < 3; i++) cycle('0, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        for (int i = 0; i < 6; i++) cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        checkValue("gie0_no_trap", 32'(inTrap), 32'd0);
        cycle(4'h2, 1'b0, 1'b0, 1'b1, SEL_GIE, 32'h1);
        cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        checkValue("gie1_trap_taken", 32'(trapTaken), 32'd1);
        checkValue("gie1_trap_cause", trapCause, 32'd1);
        cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h2, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
        cycle('0, 1'b0, 1'b0, 1'b1, SEL_GIE, 32'h0);
        for (int i = 0; i < 3; i++) cycle('0, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        for (int i = 0; i < 5; i++) cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h2, 1'b0, 1'b0, 1'b1, SEL_PENDING, 32'h2);
        cycle(4'h2, 1'b0, 1'b0, 1'b1, SEL_GIE, 32'h1);
        n_take = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(4'h2, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
            if (trapTaken === 1'b1) n_take++;
        end
        checkValue("w1c_before_enable_no_trap", 32'(n_take), 32'd0);

        // Same-cycle edge set and W1C clear on bit 0
        cycle('0, 1'b0, 1'b0, 1'b1, SEL_GIE, 32'h0);
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h1, 1'b0, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h1, 1'b0, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h1, 1'b0, 1'b0, 1'b1, SEL_PENDING, 32'h1);
        readReg(SEL_PENDING, rd);
        checkValue("set_beats_w1c", rd & 32'h1, 32'h1);

        // Reset while in the handler
        cycle(4'h1, 1'b0, 1'b0, 1'b1, SEL_GIE, 32'h1);
        cycle(4'h1, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h1, 1'b1, 1'b0, 1'b0, SEL_MASK, 32'h0);
        checkValue("intrap_before_reset", 32'(inTrap), 32'd1);
        resetActiveLow = 1'b0;
        model_reset();
        #1;
        checkOutput();
        cycle(4'h1, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
        cycle(4'h1, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
        resetActiveLow = 1'b1;
        n_ret = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(4'h1, 1'b1, 1'b1, 1'b0, SEL_MASK, 32'h0);
            if (trapReturn === 1'b1) n_ret++;
        end
        checkValue("no_return_after_reset", 32'(n_ret), 32'd0);

        // Randomized traffic against the model
        rirq = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rirq[$urandom_range(0, NUM_IRQ - 1)] ^= 1'b1;
            cycle(rirq,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Upstream trap/interrupt sequencer for the core. Synchronises external interrupt lines and latches them as pending bits.
- Decides at an instruction boundary when to take a trap.
- When it takes a trap, it pulses csrWriteEnable so the CSR unit captures the PC into MEPC, and steers the PC mux to the trap vector.
- On MRET it steers the PC mux back to mepcValue.
- Software controls it through MMIO registers on the bus interconnect.

Parameters:
- NUM_IRQ, default 4: number of external interrupt lines (1..32).
- TRAP_VECTOR, default 32'h00000100: handler entry address, driven on trapVector.
- SYNC_STAGES, default 2: flip-flop stages in each irq synchroniser (>=2).

Ports:
- clock  in  1  core clock.
- resetActiveLow  in  1  asynchronous, active-low reset.
- irqLines  in  NUM_IRQ  asynchronous, level-high interrupt requests.
- instrRetire  in  1  core is at an instruction boundary this cycle.
- mretDetected  in  1  retiring instruction is MRET; qualified by instrRetire.
- busWriteEnable  in  1  register write strobe from the interconnect.
- busRegSelect  in  2  register select: 0 = MASK, 1 = PENDING (W1C), 2 = GIE, 3 = STATUS (read-only).
- busWriteData  in  32  write data.
- busReadData  out  32  read data for the register selected by busRegSelect.
- csrWriteEnable  out  1  one-cycle pulse to the CSR unit to capture the PC.
- trapTaken  out  1  one-cycle pulse; PC mux selects trapVector.
- trapReturn  out  1  one-cycle pulse; PC mux selects mepcValue.
- trapVector  out  32  constant TRAP_VECTOR.
- trapCause  out  32  index of the interrupt taken; valid from the trapTaken cycle until the next trap.
- inTrap  out  1  high while the handler runs.

Behaviour:

Reset:
- Reset is asynchronous and active-low.
- All synchroniser flops, edge-detect flops, pending, MASK, GIE, trapCause and the FSM clear to 0; the FSM returns to IDLE.
- All pulse outputs and inTrap read 0 during and after reset.
- Reset asserted mid-trap aborts the trap; no trapReturn is issued.

Input synchronisation and pending bits:
- Each irqLines bit passes through SYNC_STAGES flops, then a rising-edge detector.
- Total latency from an irq edge to its pending bit set is SYNC_STAGES+1 cycles.
- A detected edge sets pending[i].
- A bus write to PENDING clears every bit written as 1.
- If a set and a clear land on the same bit in the same cycle, the set wins.

Registers:
- MASK[NUM_IRQ-1:0] and GIE[0] are fully writable.
- Unused upper bits ignore writes and read as 0.
- STATUS = {29'b0, state[1:0], inTrap}; writes to STATUS are ignored.
- busReadData is combinational from busRegSelect.

Eligibility and priority:
- eligible = GIE & |(pending & MASK).
- Priority is fixed: the lowest index wins.

FSM states:
- IDLE:
  - If eligible && instrRetire, go to CAPTURE and latch the winning index into trapCause.
  - mretDetected is ignored in IDLE.
- CAPTURE (exactly 1 cycle):
  - csrWriteEnable = 1 and trapTaken = 1, both registered.
  - Clear the taken pending bit; this clear overrides a same-cycle re-set of that bit.
  - Go to HANDLER.
- HANDLER:
  - inTrap = 1. No nesting: new pending bits accumulate but are not taken.
  - If mretDetected && instrRetire, go to RETURN.
- RETURN (exactly 1 cycle):
  - trapReturn = 1.
  - Go to IDLE; a new trap may be taken at the next qualifying instrRetire.

Timing:
- Pulse outputs are registered; each is high exactly one cycle per event.
- csrWriteEnable and trapTaken are never high in the same cycle as trapReturn.
- Trap latency from the qualifying instrRetire to csrWriteEnable is 1 cycle.
- A software write to MEPC on the bus wins over csrWriteEnable inside the CSR unit; this block does not arbitrate that conflict.

Test Plan:
- Reset, then write MASK=4'b0010 and GIE=1, then raise irqLines[1] with instrRetire held at 1:
  - pending[1] sets 3 cycles after the edge.
  - csrWriteEnable and trapTaken pulse one cycle later.
  - trapCause=1, inTrap=1, pending reads 0.
- Raise irqLines[2] and irqLines[0] in the same cycle with MASK=4'hF and GIE=1:
  - trapCause=0 and pending[2] stays set.
  - After MRET retires, trapReturn pulses.
  - The next instrRetire takes the trap with trapCause=2.
- In HANDLER, raise irqLines[3]:
  - No trapTaken while inTrap=1.
  - pending[3] is set and STATUS reads 3'b101.
- With GIE=0, pend irq 1:
  - No trap is taken.
  - Writing GIE=1 causes a trap on the next instrRetire.
  - W1C write 32'h2 before enabling instead results in no trap.
- In the same cycle, edge-detect a set on irq 0 and W1C-clear bit 0: pending[0] stays 1.
- Assert resetActiveLow=0 while in HANDLER:
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - No trapReturn follows.
